load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory stage directly downstream of the ALU: takes the ALU result as a byte address and runs MIPS
//  LB/LBU/LH/LHU/LW/SB/SH/SW against an internal word array. Models memory wait states with a req/resp
//  handshake so the control path can stall. Result (load data or fault) feeds the writeback mux.
// PARAMETERS
//  DEPTH        256  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH-1
//  WAIT_CYCLES  2    extra wait cycles per access (0..15); 0 = fastest
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   synchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   unit idle, can accept
//  mem_op     in   3   000 LB,001 LH,010 LW,100 LBU,101 LHU,110 SB,111 SH,011 SW
//  addr       in   32  byte address (ALU output)
//  wdata      in   32  store data; SB uses bits 7:0, SH bits 15:0
//  resp_valid out  1   one-cycle pulse: access complete
//  rdata      out  32  load result, extended to 32 bits; 0 for stores and faults
//  fault      out  1   with resp_valid: misaligned or out-of-range access
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, req_ready=1, resp_valid=0, rdata=0, fault=0, wait counter 0.
//    Memory contents NOT cleared. Reset mid-access aborts it: no write, no response.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE), combinational from state only.
//  - IDLE: on req_valid, latch mem_op/addr/wdata, load counter with WAIT_CYCLES, go to WAIT.
//    Inputs are ignored outside IDLE.
//  - WAIT: counter==0 -> go to RESP; else decrement. Exactly WAIT_CYCLES+1 cycles in WAIT.
//  - RESP: resp_valid=1 for exactly one cycle with rdata/fault, then IDLE. Accept edge T ->
//    resp_valid high in cycle T+WAIT_CYCLES+2; accept-to-accept minimum WAIT_CYCLES+3 cycles.
//  - Store write is committed on the WAIT->RESP edge; load data is read from the array at that same edge.
//  - Fault checks on latched addr: halfword needs addr[0]=0; word needs addr[1:0]=00;
//    addr >= 4*DEPTH (full 32-bit compare, no wrap) -> fault. Fault: no write, rdata=0, fault=1.
//  - Byte lanes big-endian: byte offset 0 = bits 31:24 ... offset 3 = bits 7:0;
//    halfword offset 0 = 31:16, offset 2 = 15:0.
//  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word. Stores modify only the addressed
//    lanes, other bytes of the word are preserved (read-modify-write within the same edge).
//  - rdata/fault hold their value after the pulse until the next response; sampled only with resp_valid.
//  - Word index = addr[log2(4*DEPTH)-1:2].
// TESTING
//  1 Reset: hold rst_n=0 for 2 cycles -> req_ready=1, resp_valid=0, rdata=0, fault=0.
//  2 SW addr=0x10 wdata=0x8899AABB, then LW 0x10 -> rdata=0x8899AABB, fault=0; resp_valid exactly
//    WAIT_CYCLES+2 cycles after each accept.
//  3 After case 2: LB 0x10 -> 0xFFFFFF88; LBU 0x13 -> 0x000000BB; LH 0x12 -> 0xFFFFAABB;
//    LHU 0x10 -> 0x00008899.
//  4 SB 0x11 wdata=0x00000055, SH 0x12 wdata=0x1234 -> LW 0x10 -> 0x88551234.
//  5 LW 0x12, SH 0x11, LW 4*DEPTH -> each fault=1, rdata=0; following LW 0x10 unchanged (0x88551234).
//  6 Pull rst_n low during WAIT of SW 0x20 wdata=0xDEADBEEF -> no resp_valid; later LW 0x20
//    returns prior contents; req_valid held high in WAIT/RESP does not start a second access.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS LB/LH/LW/LBU/LHU/SB/SH/SW word-array memory with wait states; req_valid/req_ready/mem_op/addr/wdata in, resp_valid/rdata/fault out
module load_store_unit #(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        fault
);
  localparam int AW = $clog2(4 * DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [2:0] op_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];
  logic is_b, is_h, is_w, uns, st, flt, done;
  logic [AW-3:0] idx;
  logic [4:0] bsh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] cur, ld, mask, sdat;
  always_comb begin
    state_n = state == IDLE ? (req_valid ? WAIT : IDLE) :
              state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    done = state == WAIT && cnt == 4'd0;
  end
  always_comb begin
    is_b = op_q[1:0] == 2'b00 || op_q == 3'b110;
    is_h = op_q[1:0] == 2'b01 || op_q == 3'b111;
    is_w = !is_b && !is_h;
    uns = op_q[2:1] == 2'b10;
    st = op_q == 3'b011 || op_q[2:1] == 2'b11;
    flt = addr_q >= 32'(4 * DEPTH) || (is_h && addr_q[0]) || (is_w && addr_q[1:0] != 2'b00);
    idx = addr_q[AW-1:2];
    cur = mem[idx];
    bsh = {~addr_q[1:0], 3'b000};
    b = 8'(cur >> bsh);
    h = addr_q[1] ? cur[15:0] : cur[31:16];
    ld = is_b ? {{24{b[7] & !uns}}, b} : is_h ? {{16{h[15] & !uns}}, h} : cur;
    mask = is_b ? 32'hFF << bsh : is_h ? (addr_q[1] ? 32'h0000FFFF : 32'hFFFF0000) : 32'hFFFFFFFF;
    sdat = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata <= 32'd0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        op_q <= mem_op;
        addr_q <= addr;
        wdata_q <= wdata;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        rdata <= flt || st ? 32'd0 : ld;
        fault <= flt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && done && st && !flt) mem[idx] <= (cur & ~mask) | (sdat & mask);
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a byte-array reference model
module tb_load_store_unit;
  localparam int D = 256;
  localparam int W = 2;
  logic clk = 0, rst_n = 0, req_valid = 0, req_ready, resp_valid, fault;
  logic [2:0] mem_op = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  typedef struct {logic [31:0] rd; logic f; int due;} exp_t;
  exp_t sb[$];
  logic [7:0] mb [4*D];
  int cyc = 0, n_chk = 0, n_fail = 0;

  load_store_unit #(.DEPTH(D), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rdata, e.rd);
        chk("fault", {31'd0, fault}, {31'd0, e.f});
        chk("latency", cyc, e.due);
      end
    end
  end

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int sz;
    bit sgn, store;
    logic [31:0] v;
    sz = (op == 3'b000 || op == 3'b100 || op == 3'b110) ? 1 :
         (op == 3'b001 || op == 3'b101 || op == 3'b111) ? 2 : 4;
    sgn = op == 3'b000 || op == 3'b001;
    store = op == 3'b110 || op == 3'b111 || op == 3'b011;
    e.f = a >= 4 * D || a % sz != 0;
    e.rd = 0;
    e.due = 0;
    if (!e.f) begin
      if (store) begin
        for (int i = 0; i < sz; i++) mb[a + i] = 8'(wd >> (8 * (sz - 1 - i)));
      end else begin
        v = 0;
        for (int i = 0; i < sz; i++) v = (v << 8) | 32'(mb[a + i]);
        if (sgn && v[sz*8-1]) v = v | (32'hFFFFFFFF << (sz * 8));
        e.rd = v;
      end
    end
    return e;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input bit dir, input logic [31:0] xr, input logic xf);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    e = model(op, a, wd);
    if (dir) begin
      e.rd = xr;
      e.f = xf;
    end
    mem_op = op;
    addr = a;
    wdata = wd;
    req_valid = 1;
    @(posedge clk);
    #1;
    e.due = cyc + W + 1;
    sb.push_back(e);
    if (hold) begin
      mem_op = 3'b011;
      addr = 32'h20;
      wdata = $urandom;
    end else req_valid = 0;
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    t = 0;
    while (sb.size() > 0 && t < 50) begin
      @(negedge clk);
      #1;
      if (resp_valid) req_valid = 0;
      t++;
    end
    req_valid = 0;
    if (sb.size() > 0) begin
      chk("resp_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) do_op(3'b011, 32'(4 * i), $urandom, 0, 0, 0, 0);
    do_op(3'b011, 32'h10, 32'h8899AABB, 0, 1, 32'h0, 0);
    do_op(3'b010, 32'h10, 32'h0, 0, 1, 32'h8899AABB, 0);
    do_op(3'b000, 32'h10, 32'h0, 0, 1, 32'hFFFFFF88, 0);
    do_op(3'b100, 32'h13, 32'h0, 0, 1, 32'h000000BB, 0);
    do_op(3'b001, 32'h12, 32'h0, 0, 1, 32'hFFFFAABB, 0);
    do_op(3'b101, 32'h10, 32'h0, 0, 1, 32'h00008899, 0);
    do_op(3'b110, 32'h11, 32'h00000055, 0, 1, 32'h0, 0);
    do_op(3'b111, 32'h12, 32'h00001234, 0, 1, 32'h0, 0);
    do_op(3'b010, 32'h10, 32'h0, 0, 1, 32'h88551234, 0);
    do_op(3'b010, 32'h12, 32'h0, 0, 1, 32'h0, 1);
    do_op(3'b111, 32'h11, 32'hFFFF, 0, 1, 32'h0, 1);
    do_op(3'b010, 32'(4 * D), 32'h0, 0, 1, 32'h0, 1);
    do_op(3'b010, 32'h10, 32'h0, 0, 1, 32'h88551234, 0);
    @(negedge clk);
    mem_op = 3'b011;
    addr = 32'h20;
    wdata = 32'hDEADBEEF;
    req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_fault", {31'd0, fault}, 32'd0);
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    do_op(3'b010, 32'h20, 32'h0, 0, 0, 0, 0);
    do_op(3'b010, 32'h10, 32'h0, 1, 1, 32'h88551234, 0);
    do_op(3'b110, 32'h21, 32'h000000A5, 1, 0, 0, 0);
    do_op(3'b010, 32'h20, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom);
      case ($urandom_range(0, 9))
        0: a = 32'(4 * D) + $urandom_range(0, 7);
        1: a = 32'hFFFFFFF0 + $urandom_range(0, 15);
        default: a = $urandom_range(0, 63);
      endcase
      do_op(op, a, $urandom, $urandom_range(0, 3) == 0, 0, 0, 0);
    end
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
